// File: rtl/alu_pkg.sv
// Shared constants and decode helper for the bit-serial ALU sequencer.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_SUM  = 2'b10;
    localparam logic [1:0] OP_LESS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    typedef struct packed {
        logic       legal;
        logic       ainvert;
        logic       bnegate;
        logic [1:0] op;
    } ctl_t;

    // Unknown codes decode to a harmless AND with legal=0 so the result is forced to zero.
    function automatic ctl_t decode(input logic [3:0] code);
        ctl_t c;
        c = '{legal: 1'b1, ainvert: 1'b0, bnegate: 1'b0, op: OP_AND};
        case (code)
            ALU_AND: c.op = OP_AND;
            ALU_OR:  c.op = OP_OR;
            ALU_ADD: c.op = OP_SUM;
            ALU_SUB: begin c.bnegate = 1'b1; c.op = OP_SUM;  end
            ALU_SLT: begin c.bnegate = 1'b1; c.op = OP_LESS; end
            ALU_NOR: begin c.ainvert = 1'b1; c.bnegate = 1'b1; c.op = OP_AND; end
            default: c.legal = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/serial_alu_seq_if.sv
// Control-unit side handshake and result bus of the bit-serial ALU sequencer.
interface serial_alu_seq_if #(parameter int WIDTH = 32);

    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [3:0]       alu_ctl;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start, a_in, b_in, alu_ctl,
        input  busy, done, result, zero, carry_out, overflow
    );

    modport slave (
        input  start, a_in, b_in, alu_ctl,
        output busy, done, result, zero, carry_out, overflow
    );

endinterface

// File: rtl/alu_1bit.sv
// Purely combinational 1-bit ALU slice with operand inversion and carry chain.
module alu_1bit
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic       ainvert,
    input  logic       bnegate,
    input  logic       less,
    input  logic [1:0] op,
    output logic       result,
    output logic       cout,
    output logic       sum
);

    logic aa;
    logic bb;

    always_comb begin
        aa   = a ^ ainvert;
        bb   = b ^ bnegate;
        sum  = aa ^ bb ^ cin;
        cout = (aa & bb) | (aa & cin) | (bb & cin);
        case (op)
            OP_AND:  result = aa & bb;
            OP_OR:   result = aa | bb;
            OP_SUM:  result = sum;
            default: result = less;
        endcase
    end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: one alu_1bit slice plus a carry flop, LSB first.
module serial_alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic            clk,
    input  logic            reset,
    serial_alu_seq_if.slave bus
);

    state_t           state;
    ctl_t             ctl;
    ctl_t             dec;
    logic [CNT_W-1:0] count;
    logic             carry;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;

    logic             slice_res;
    logic             slice_cout;
    logic             slice_sum;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] final_res;
    logic             final_co;
    logic             final_ov;
    logic             ovf;
    logic             last;

    alu_1bit u_slice (
        .a       (a_sh[0]),
        .b       (b_sh[0]),
        .cin     (carry),
        .ainvert (ctl.ainvert),
        .bnegate (ctl.bnegate),
        .less    (1'b0),
        .op      (ctl.op),
        .result  (slice_res),
        .cout    (slice_cout),
        .sum     (slice_sum)
    );

    // On the MSB step the carry flop holds the carry into the MSB and the slice gives the carry out.
    always_comb begin
        dec       = decode(bus.alu_ctl);
        last      = (count == CNT_W'(WIDTH - 1));
        ovf       = carry ^ slice_cout;
        shifted   = {slice_res, res_sh[WIDTH-1:1]};
        final_res = shifted;
        final_co  = 1'b0;
        final_ov  = 1'b0;
        if (!ctl.legal) begin
            final_res = '0;
        end else if (ctl.op == OP_LESS) begin
            final_res = WIDTH'(slice_sum ^ ovf);
            final_ov  = ovf;
        end else if (ctl.op == OP_SUM) begin
            final_co  = slice_cout;
            final_ov  = ovf;
        end
    end

    // Result and flags are loaded on the last RUN edge so they are valid while done is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            ctl           <= '0;
            count         <= '0;
            carry         <= 1'b0;
            a_sh          <= '0;
            b_sh          <= '0;
            res_sh        <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.result    <= '0;
            bus.zero      <= 1'b1;
            bus.carry_out <= 1'b0;
            bus.overflow  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_sh     <= bus.a_in;
                        b_sh     <= bus.b_in;
                        ctl      <= dec;
                        count    <= '0;
                        carry    <= dec.bnegate;
                        bus.busy <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= shifted;
                    carry  <= slice_cout;
                    if (last) begin
                        count         <= '0;
                        bus.done      <= 1'b1;
                        bus.result    <= final_res;
                        bus.zero      <= (final_res == '0);
                        bus.carry_out <= final_co;
                        bus.overflow  <= final_ov;
                        state         <= ST_DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                ST_DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
